multdiv_ctrl: RTL and testbench

//  Front-end sequencer for the shared multiply/divide unit, sitting between the execute stage and the

---
 rtl/multdiv_pkg.sv | 35 +++
 rtl/multdiv_counter.sv | 31 +++
 rtl/multdiv_ctrl.sv | 162 ++++++++++++++++
 tb/tb_multdiv_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_pkg : shared types and constants for the multiply/divide sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package multdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MLOAD = 3'd1,
    S_MRUN  = 3'd2,
    S_DLOAD = 3'd3,
    S_DRUN  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Which result path DONE should use.
  typedef enum logic [1:0] {
    OP_MULT    = 2'd0,
    OP_DIV     = 2'd1,
    OP_DIVSPEC = 2'd2
  } op_t;

  localparam int          MULT_ITERS_DEF = 16;
  localparam int          DIV_ITERS_DEF  = 32;
  localparam logic [31:0] INT_MIN        = 32'h8000_0000;

  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/multdiv_counter.sv
// ---------------------------------------------------------------------------
// multdiv_counter : iteration counter with sync clear and terminal-count flag
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multdiv_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == limit);

endmodule

`default_nettype wire

// File: rtl/multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_ctrl : operand latch, engine sequencing and result fixup for the
//                shared iterative multiply/divide unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module multdiv_ctrl
  import multdiv_pkg::*;
#(
  parameter int MULT_ITERS = MULT_ITERS_DEF,
  parameter int DIV_ITERS  = DIV_ITERS_DEF,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] eng_a,
  output logic [31:0] eng_b,
  output logic        mult_first,
  output logic        mult_en,
  input  logic [31:0] mult_lo,
  input  logic [31:0] mult_hi,
  output logic        div_first,
  output logic        div_en,
  input  logic [31:0] div_quot,
  output logic        busy,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(MULT_ITERS - 1);
  localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DIV_ITERS - 1);

  state_t           state;
  op_t              op;
  logic             neg_q;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             cnt_en;
  logic             cnt_clr;
  logic [CNT_W-1:0] limit;
  logic             start;
  logic             div_spec;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign div_spec = (data_operandB == 32'd0) ||
                    ((data_operandA == INT_MIN) && (data_operandB == 32'hFFFF_FFFF));
  assign cnt_en   = (state == S_MRUN) || (state == S_DRUN);
  assign cnt_clr  = start || (cnt_en && tc);
  assign limit    = (state == S_DRUN) ? D_LAST : M_LAST;

  multdiv_counter #(.CNT_W(CNT_W)) u_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (limit),
    .count (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op             <= OP_MULT;
      neg_q          <= 1'b0;
      eng_a          <= '0;
      eng_b          <= '0;
      mult_first     <= 1'b0;
      mult_en        <= 1'b0;
      div_first      <= 1'b0;
      div_en         <= 1'b0;
      busy           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      mult_first     <= 1'b0;
      div_first      <= 1'b0;
      data_resultRDY <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      // A start pulse aborts whatever is in flight, including a pending DONE.
      if (start) begin
        if (ctrl_MULT) begin
          eng_a      <= data_operandA;
          eng_b      <= data_operandB;
          op         <= OP_MULT;
          state      <= S_MLOAD;
          mult_first <= 1'b1;
          mult_en    <= 1'b1;
          div_en     <= 1'b0;
          busy       <= 1'b1;
        end else begin
          eng_a   <= abs32(data_operandA);
          eng_b   <= abs32(data_operandB);
          neg_q   <= data_operandA[31] ^ data_operandB[31];
          mult_en <= 1'b0;
          if (div_spec) begin
            op     <= OP_DIVSPEC;
            state  <= S_DONE;
            div_en <= 1'b0;
            busy   <= 1'b0;
          end else begin
            op        <= OP_DIV;
            state     <= S_DLOAD;
            div_first <= 1'b1;
            div_en    <= 1'b1;
            busy      <= 1'b1;
          end
        end
      end else begin
        case (state)
          S_MLOAD: state <= S_MRUN;
          S_MRUN: begin
            if (tc) begin
              state   <= S_DONE;
              mult_en <= 1'b0;
              busy    <= 1'b0;
            end
          end
          S_DLOAD: state <= S_DRUN;
          S_DRUN: begin
            if (tc) begin
              state  <= S_DONE;
              div_en <= 1'b0;
              busy   <= 1'b0;
            end
          end
          // Engine outputs have settled by now; register the final result.
          S_DONE: begin
            state          <= S_IDLE;
            data_resultRDY <= 1'b1;
            case (op)
              OP_MULT: begin
                data_result    <= mult_lo;
                data_exception <= (mult_hi != {32{mult_lo[31]}});
              end
              OP_DIV: begin
                data_result    <= neg_q ? (~div_quot + 32'd1) : div_quot;
                data_exception <= 1'b0;
              end
              default: begin
                data_result    <= '0;
                data_exception <= 1'b1;
              end
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multdiv_ctrl : self-checking bench with behavioural engines and model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_multdiv_ctrl;

  localparam int MULT_ENABLES = 17;
  localparam int DIV_ENABLES  = 33;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] eng_a, eng_b;
  logic        mult_first, mult_en, div_first, div_en;
  logic [31:0] mult_lo, mult_hi, div_quot;
  logic        busy;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multdiv_ctrl dut (
    .clk(clk), .rst(rst), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .eng_a(eng_a), .eng_b(eng_b), .mult_first(mult_first), .mult_en(mult_en),
    .mult_lo(mult_lo), .mult_hi(mult_hi), .div_first(div_first), .div_en(div_en),
    .div_quot(div_quot), .busy(busy), .data_result(data_result),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY)
  );

  // Behavioural engines: a correct result appears only after exactly the
  // right number of enabled edges, otherwise a junk pattern is presented.
  logic [31:0] m_a = '0, m_b = '0, d_a = '0, d_b = '0;
  int          m_cnt = 0, d_cnt = 0, div_en_seen = 0;
  logic [63:0] m_prod;

  always @(posedge clk) begin
    if (mult_en) begin
      if (mult_first) begin
        m_cnt <= 1; m_a <= eng_a; m_b <= eng_b;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
    if (div_en) begin
      div_en_seen <= div_en_seen + 1;
      if (div_first) begin
        d_cnt <= 1; d_a <= eng_a; d_b <= eng_b;
      end else begin
        d_cnt <= d_cnt + 1;
      end
    end
  end

  assign m_prod = $signed({{32{m_a[31]}}, m_a}) * $signed({{32{m_b[31]}}, m_b});
  assign {mult_hi, mult_lo} = (m_cnt == MULT_ENABLES) ? m_prod : 64'hA5A5_5A5A_C3C3_3C3C;
  assign div_quot = (d_cnt == DIV_ENABLES && d_b != 0) ? d_a / d_b : 32'hA5A5_5A5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic plus the documented latencies.
  function automatic void ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
    longint p;
    int     lo, sa, sb, q;
    sa = a; sb = b;
    if (is_mult) begin
      p   = longint'(sa) * longint'(sb);
      lo  = int'(p[31:0]);
      r   = p[31:0];
      e   = (p != longint'(lo));
      lat = 18;
    end else if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) begin
      r = 32'd0; e = 1'b1; lat = 1;
    end else begin
      q = sa / sb;
      r = q; e = 1'b0; lat = 34;
    end
  endfunction

  task automatic start_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ctrl_MULT = is_mult; ctrl_DIV = !is_mult;
    data_operandA = a; data_operandB = b;
    @(posedge clk); #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_rdy(input string tag, input int exp_lat,
                          input logic [31:0] exp_r, input logic exp_e);
    int n;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (data_resultRDY) begin
        n = i;
        break;
      end
    end
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_res"}, data_result, exp_r);
    check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, exp_e});
    @(posedge clk); #1;
    check({tag, "_rdy_busy_after"}, {30'd0, data_resultRDY, busy}, 32'd0);
  endtask

  task automatic run_op(input string tag, input bit is_mult, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    int          lat, seen0;
    ref_op(is_mult, a, b, r, e, lat);
    seen0 = div_en_seen;
    start_op(is_mult, a, b);
    if (is_mult)
      check({tag, "_mfirst"}, {30'd0, mult_first, mult_en}, 32'd3);
    else if (lat != 1)
      check({tag, "_dfirst"}, {30'd0, div_first, div_en}, 32'd3);
    wait_rdy(tag, lat, r, e);
    if (!is_mult && lat == 1)
      check({tag, "_no_div_en"}, div_en_seen - seen0, 32'd0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return $urandom_range(0, 200) - 100;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int extra;
    rst = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_eng_a", eng_a, 32'd0);
    check("rst_eng_b", eng_b, 32'd0);
    check("rst_res", data_result, 32'd0);
    check("rst_ctl", {25'd0, mult_first, mult_en, div_first, div_en, busy,
                      data_exception, data_resultRDY}, 32'd0);
    rst = 1'b0;

    run_op("mul_7_m3",       1'b1, 32'd7, -32'sd3);
    run_op("mul_ovf",        1'b1, 32'h0001_0000, 32'h0001_0000);
    run_op("div_100_m7",     1'b0, 32'd100, -32'sd7);
    run_op("div_m100_7",     1'b0, -32'sd100, 32'd7);
    run_op("div_by0",        1'b0, 32'd5, 32'd0);
    run_op("div_intmin_m1",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_intmin_1",   1'b0, 32'h8000_0000, 32'd1);

    // Abort a multiply with a divide pulse on edge 8.
    start_op(1'b1, 32'd3, 32'd4);
    extra = 0;
    for (int i = 1; i <= 7; i++) begin
      @(posedge clk); #1;
      if (data_resultRDY) extra++;
    end
    start_op(1'b0, 32'd9, 32'd2);
    wait_rdy("abort_div", 34, 32'd4, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (data_resultRDY) extra++;
    end
    check("abort_no_extra_rdy", extra, 32'd0);

    // Reset on edge 10 of a multiply.
    start_op(1'b1, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_eng", eng_a | eng_b | data_result, 32'd0);
    check("midrst_ctl", {25'd0, mult_first, mult_en, div_first, div_en, busy,
                         data_exception, data_resultRDY}, 32'd0);
    rst = 1'b0;
    run_op("post_rst_2x2", 1'b1, 32'd2, 32'd2);

    for (int k = 0; k < 24; k++) begin
      run_op($sformatf("rnd%0d", k), 1'($urandom_range(0, 1)), rnd_operand(), rnd_operand());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
